my_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the instruction decoder.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Latches the returned word into `ir`, which feeds the decoder directly, and holds it until the consumer accepts it.
- Handles branch redirects, including squashing an in-flight fetch.

---
 rtl/my_fetch_pkg.sv | 25 ++
 rtl/my_fetch.sv | 143 ++++++++++++++
 tb/tb_my_fetch.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/my_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// instruction width, reset PC default and the no-op instruction word.
package my_fetch_pkg;

  localparam int INSTR_W = 16;

  // Default PC after reset; the fetch block narrows it to its PC width.
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;

  // Word placed in ir whenever no live instruction is held.
  localparam logic [INSTR_W-1:0] NOP_IR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  // The memory request is active in the two bus-owning states.
  function automatic logic is_bus_state(input fetch_state_e s);
    return (s == REQ) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/my_fetch.sv
// Instruction fetch stage. Holds the PC, fetches one word at a time over a
// req/ack handshake, presents it to the decoder in ir until consumed, and
// handles branch redirects including squashing a fetch already on the bus.
module my_fetch
  import my_fetch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                stall,
  input  logic                br_taken,
  input  logic [PC_W-1:0]     br_target,
  output logic [INSTR_W-1:0]  ir,
  output logic                ir_valid,
  output logic [PC_W-1:0]     ir_pc
);

  localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0] PC_ZERO = {PC_W{1'b0}};

  fetch_state_e         state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [PC_W-1:0]      pc_next_q, pc_next_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic                 ir_valid_q, ir_valid_d;
  logic [PC_W-1:0]      ir_pc_q, ir_pc_d;
  logic                 consume;

  assign consume = ir_valid_q & ~stall;

  // Next-state and datapath decode for the fetch sequence.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_next_d  = pc_next_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    ir_pc_d    = ir_pc_q;
    case (state_q)
      IDLE: begin
        if (br_taken) begin
          pc_d = br_target;
        end else begin
          pc_d = pc_q;
        end
        state_d = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          if (br_taken) begin
            // Returned word belongs to the old path; refetch from the target.
            pc_d    = br_target;
            state_d = REQ;
          end else begin
            ir_d       = imem_rdata;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + PC_ONE;
            state_d    = HOLD;
          end
        end else begin
          if (br_taken) begin
            // Address must stay on the bus until acked; park the target.
            pc_next_d = br_target;
            state_d   = DRAIN;
          end else begin
            state_d = REQ;
          end
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          // A redirect arriving in the ack cycle is the newest one.
          if (br_taken) begin
            pc_d = br_target;
          end else begin
            pc_d = pc_next_q;
          end
          state_d = REQ;
        end else begin
          if (br_taken) begin
            pc_next_d = br_target;
          end else begin
            pc_next_d = pc_next_q;
          end
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (br_taken) begin
          ir_d       = NOP_IR;
          ir_valid_d = 1'b0;
          pc_d       = br_target;
          state_d    = REQ;
        end else if (consume) begin
          ir_d       = NOP_IR;
          ir_valid_d = 1'b0;
          state_d    = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d    = IDLE;
        ir_d       = NOP_IR;
        ir_valid_d = 1'b0;
      end
    endcase
  end

  // State, PC and instruction registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pc_next_q  <= RESET_PC;
      ir_q       <= NOP_IR;
      ir_valid_q <= 1'b0;
      ir_pc_q    <= PC_ZERO;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_next_q  <= pc_next_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      ir_pc_q    <= ir_pc_d;
    end
  end

  // In DRAIN pc_q still holds the squashed address, so the bus stays stable.
  assign imem_req  = is_bus_state(state_q);
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign ir_pc     = ir_pc_q;

endmodule

// File: tb/tb_my_fetch.sv
// Self-checking bench for my_fetch: random memory/consumer/redirect stimulus
// compared every cycle against a transaction-level fetch model.
module tb_my_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'h0000;
  logic [15:0] ir;
  logic        ir_valid;
  logic [15:0] ir_pc;

  int checks = 0;
  int errors = 0;

  // Reference model: fetch bookkeeping in terms of a bus transaction
  // (busy / dead) and the address the next fetch will use.
  bit          m_idle;
  bit          m_req;
  bit          m_dead;
  bit          m_have_ir;
  logic [15:0] m_addr;
  logic [15:0] m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_ir_pc;

  always #5 clk = ~clk;

  my_fetch #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .ir_pc      (ir_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle    = 1'b1;
    m_req     = 1'b0;
    m_dead    = 1'b0;
    m_have_ir = 1'b0;
    m_addr    = 16'h0000;
    m_pc      = 16'h0000;
    m_ir      = 16'h0000;
    m_ir_pc   = 16'h0000;
  endtask

  task automatic model_step(input bit ack, input logic [15:0] rdata, input bit stl,
                            input bit br, input logic [15:0] tgt);
    if (m_idle) begin
      m_idle = 1'b0;
      if (br) m_pc = tgt;
      m_req  = 1'b1;
      m_addr = m_pc;
    end else if (m_have_ir) begin
      if (br) begin
        m_have_ir = 1'b0;
        m_ir      = 16'h0000;
        m_pc      = tgt;
        m_req     = 1'b1;
        m_addr    = m_pc;
      end else if (!stl) begin
        m_have_ir = 1'b0;
        m_ir      = 16'h0000;
        m_req     = 1'b1;
        m_addr    = m_pc;
      end
    end else if (m_req) begin
      if (ack) begin
        if (m_dead || br) begin
          if (br) m_pc = tgt;
          m_dead = 1'b0;
          m_addr = m_pc;
        end else begin
          m_ir      = rdata;
          m_ir_pc   = m_addr;
          m_have_ir = 1'b1;
          m_req     = 1'b0;
          m_pc      = m_addr + 16'd1;
        end
      end else if (br) begin
        m_dead = 1'b1;
        m_pc   = tgt;
      end
    end
  endtask

  task automatic cycle_step();
    @(posedge clk);
    model_step(imem_ack, imem_rdata, stall, br_taken, br_target);
    @(negedge clk);
    check("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    if (m_req) check("imem_addr", {16'd0, imem_addr}, {16'd0, m_addr});
    check("ir_valid", {31'd0, ir_valid}, {31'd0, m_have_ir});
    check("ir", {16'd0, ir}, {16'd0, m_ir});
    check("ir_pc", {16'd0, ir_pc}, {16'd0, m_ir_pc});
  endtask

  task automatic drive_random();
    imem_ack   = ($urandom_range(99) < 40);
    imem_rdata = 16'($urandom);
    stall      = ($urandom_range(99) < 30);
    br_taken   = ($urandom_range(99) < 10);
    case ($urandom_range(3))
      0:       br_target = 16'hFFFF;
      1:       br_target = 16'hFFFE;
      default: br_target = 16'($urandom);
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},      {31'd0, imem_req}, 32'd0);
    check({tag, "_addr"},     {16'd0, imem_addr}, 32'd0);
    check({tag, "_ir"},       {16'd0, ir}, 32'd0);
    check({tag, "_ir_valid"}, {31'd0, ir_valid}, 32'd0);
    check({tag, "_ir_pc"},    {16'd0, ir_pc}, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    imem_ack = 1'b0;
    stall    = 1'b0;
    br_taken = 1'b0;
    rst_n    = 1'b1;
    model_reset();
  endtask

  initial begin
    bit found;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    release_reset();

    // Opening: memory acks every request with a fixed word, no stall.
    for (int i = 0; i < 6; i++) begin
      cycle_step();
      imem_ack   = 1'b1;
      imem_rdata = 16'h5008;
      stall      = 1'b0;
      br_taken   = 1'b0;
    end

    for (int i = 0; i < 3000; i++) begin
      drive_random();
      cycle_step();
    end

    // Steer into a squashed fetch, then pull reset asynchronously.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_req && !m_dead) begin
        found = 1'b1;
      end else begin
        imem_ack = 1'b1;
        stall    = 1'b0;
        br_taken = 1'b0;
        cycle_step();
      end
    end
    check("reach_req", {31'd0, found}, 32'd1);
    if (found) begin
      imem_ack  = 1'b0;
      br_taken  = 1'b1;
      br_target = 16'h0020;
      cycle_step();
      br_taken = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_reset_outputs("async_rst");
    end
    rst_n = 1'b0;
    release_reset();

    for (int i = 0; i < 1000; i++) begin
      drive_random();
      cycle_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
